wheel_speed_sequencer: RTL
==========================

WHEEL_SPEED_SEQUENCER -- requirements
Module: wheel_speed_sequencer

Interface
REQ-001 SHALL have parameter PERIOD, default 500000, window length in theClock cycles (10 ms at 50 MHz); legal range 2..2^32-1.
REQ-002 SHALL have parameter INVERT_RIGHT, default 1, meaning right-wheel count sign is negated (mirror-mounted motor).
REQ-003 theClock  in  1  system clock (CLOCK_50).
REQ-004 theReset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  measurement enable, synchronous.
REQ-006 left_a, left_b, right_a, right_b  in  1 each  raw asynchronous quadrature encoder inputs.
REQ-007 rd_ack  in  1  one-cycle pulse from SPI side: current snapshot consumed.
REQ-008 speed_left, speed_right  out  16  signed two's-complement quadrature steps per window.
REQ-009 snap_valid  out  1  unread snapshot present.
REQ-010 overrun  out  1  sticky: snapshot overwritten before rd_ack.
REQ-011 err_count  out  8  saturating count of illegal quadrature transitions, both wheels.
REQ-012 busy  out  1  high when state is RUN.

Function
REQ-013 Each encoder input SHALL pass a 2-flop synchronizer followed by one history flop; decode uses synchronized current vs history value (input-to-count latency 3 cycles).
REQ-014 Decode SHALL be x4: one step per legal A/B Gray transition; 00->01->11->10->00 = +1, reverse = -1 (before INVERT_RIGHT).
REQ-015 Transition where A and B change in the same cycle SHALL add no step and SHALL increment err_count by 1 (by 2 if both wheels err same cycle), saturating at 255.
REQ-016 States: IDLE, ARM, RUN; encoding free.
REQ-017 IDLE: timer=0, accumulators=0; enable=1 -> ARM next cycle.
REQ-018 ARM: one cycle; timer=0, accumulators=0, synchronizer history reloaded so no false step; -> RUN.
REQ-019 RUN: timer increments each cycle; steps decoded in the cycle are added to per-wheel accumulator.
REQ-020 In RUN, on cycle with timer==PERIOD-1: at that clock edge speed_* SHALL load accumulator plus that cycle's step, snap_valid SHALL set, timer SHALL go to 0, accumulator SHALL go to 0; window is exactly PERIOD cycles, no step lost or double counted.
REQ-021 Accumulators SHALL be 16-bit signed saturating: hold at +32767 / -32768, never wrap.
REQ-022 rd_ack with snap_valid=1 SHALL clear snap_valid next cycle; rd_ack with snap_valid=0 SHALL be ignored.
REQ-023 Snapshot while snap_valid=1 and no rd_ack same cycle SHALL set overrun and overwrite speed_*; snap_valid stays 1.
REQ-024 Snapshot coinciding with rd_ack SHALL leave snap_valid=1, overrun unchanged.
REQ-025 overrun SHALL clear only on theReset or on IDLE->ARM transition.
REQ-026 enable=0 in any state SHALL go to IDLE next cycle, discarding partial window; speed_* and snap_valid hold.
REQ-027 err_count clears only on theReset.

Reset
REQ-028 theReset=1 SHALL, at next theClock edge, force IDLE, timer=0, accumulators=0, speed_left=speed_right=0, snap_valid=0, overrun=0, err_count=0, busy=0, synchronizer flops=0; reset dominates enable and rd_ack; reset mid-window discards window.
REQ-029 First 3 cycles after reset release SHALL not generate steps or errors from synchronizer fill.

Verification (PERIOD=100 in bench)
REQ-030 Reset, enable=1, left sequence 00,01,11,10,00 each held 5 cycles, right idle -> after first window speed_left=+4, speed_right=0, snap_valid=1, err_count=0.
REQ-031 Right reverse rotation 12 steps, INVERT_RIGHT=1 -> speed_right=+12; INVERT_RIGHT=0 -> -12.
REQ-032 Two windows without rd_ack -> overrun=1, speed_* = second window; rd_ack pulse -> snap_valid=0, overrun stays 1; toggle enable 0/1 -> overrun=0.
REQ-033 Left A and B flipped same cycle (00->11) -> err_count=1, speed_left=0; drive 300 such events -> err_count=255.
REQ-034 Steps injected on cycle timer==99 and timer==0 of next window -> each counted exactly once, in respective windows; rd_ack on snapshot cycle -> snap_valid=1, overrun=0.
REQ-035 Forward stepping every cycle for 40000-cycle window -> speed_left=32767; enable dropped at timer=50 -> busy=0 next cycle, outputs unchanged, no snapshot.

Source files
------------

// File: rtl/wheel_speed_sequencer.sv
// Dual-wheel quadrature speed sequencer: x4 decode per wheel, windowed step count,
// snapshot handshake with overrun flag and a shared illegal-transition error counter.
module wheel_speed_sequencer #(
  parameter int unsigned PERIOD       = 500000,
  parameter bit          INVERT_RIGHT = 1'b1
) (
  input  logic        theClock,
  input  logic        theReset,
  input  logic        enable,
  input  logic        left_a,
  input  logic        left_b,
  input  logic        right_a,
  input  logic        right_b,
  input  logic        rd_ack,
  output logic [15:0] speed_left,
  output logic [15:0] speed_right,
  output logic        snap_valid,
  output logic        overrun,
  output logic [7:0]  err_count,
  output logic        busy
);

  localparam int unsigned TW = 32;
  localparam int unsigned SW = 16;
  localparam int unsigned EW = 8;
  localparam logic [TW-1:0] LAST_TICK = TW'(PERIOD - 1);
  localparam logic [SW-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [SW-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      sync1_q, sync1_d;
  logic [3:0]      sync2_q, sync2_d;
  logic [3:0]      hist_q, hist_d;
  logic [1:0]      fill_q, fill_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [SW-1:0]   acc_l_q, acc_l_d;
  logic [SW-1:0]   acc_r_q, acc_r_d;
  logic [SW-1:0]   speed_l_q, speed_l_d;
  logic [SW-1:0]   speed_r_q, speed_r_d;
  logic            snap_q, snap_d;
  logic            ovr_q, ovr_d;
  logic [EW-1:0]   err_q, err_d;
  logic            busy_q, busy_d;

  logic            dec_en;
  logic [1:0]      dl, dr;
  logic            l_up, l_dn, r_up, r_dn, err_l, err_r;
  logic            r_fwd, r_rev;
  logic [SW-1:0]   new_l, new_r;
  logic [EW:0]     err_sum;
  logic            snap_fire;
  logic            ovr_clr;

  // Map a Gray A/B pair onto a 0..3 position around the x4 cycle.
  function automatic logic [1:0] gray_pos(input logic a, input logic b);
    return {a, a ^ b};
  endfunction

  function automatic logic [SW-1:0] sat_step(input logic [SW-1:0] acc,
                                             input logic up, input logic dn);
    logic [SW-1:0] res;
    res = acc;
    if (up && (acc != SAT_MAX)) res = acc + SW'(1);
    if (dn && (acc != SAT_MIN)) res = acc - SW'(1);
    return res;
  endfunction

  always_ff @(posedge theClock) begin
    if (theReset) begin
      state_q   <= S_IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      timer_q   <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      speed_l_q <= '0;
      speed_r_q <= '0;
      snap_q    <= 1'b0;
      ovr_q     <= 1'b0;
      err_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      timer_q   <= timer_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      speed_l_q <= speed_l_d;
      speed_r_q <= speed_r_d;
      snap_q    <= snap_d;
      ovr_q     <= ovr_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  // Synchronizers and step/error decode; history always tracks, so ARM sees no stale delta.
  always_comb begin
    sync1_d = {left_a, left_b, right_a, right_b};
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    fill_d  = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    dec_en  = (fill_q == 2'd3);

    dl = gray_pos(sync2_q[3], sync2_q[2]) - gray_pos(hist_q[3], hist_q[2]);
    dr = gray_pos(sync2_q[1], sync2_q[0]) - gray_pos(hist_q[1], hist_q[0]);

    l_up  = dec_en && (dl == 2'd1);
    l_dn  = dec_en && (dl == 2'd3);
    err_l = dec_en && (dl == 2'd2);
    r_fwd = dec_en && (dr == 2'd1);
    r_rev = dec_en && (dr == 2'd3);
    err_r = dec_en && (dr == 2'd2);
    r_up  = INVERT_RIGHT ? r_rev : r_fwd;
    r_dn  = INVERT_RIGHT ? r_fwd : r_rev;

    new_l = sat_step(acc_l_q, l_up, l_dn);
    new_r = sat_step(acc_r_q, r_up, r_dn);

    err_sum = {1'b0, err_q} + (EW+1)'(err_l) + (EW+1)'(err_r);
    err_d   = err_sum[EW] ? {EW{1'b1}} : err_sum[EW-1:0];
  end

  // Sequencer: next state, window timer, accumulators, snapshot handshake.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    speed_l_d = speed_l_q;
    speed_r_d = speed_r_q;
    snap_d    = snap_q;
    ovr_d     = ovr_q;
    snap_fire = 1'b0;
    ovr_clr   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        acc_l_d = '0;
        acc_r_d = '0;
        if (enable) begin
          state_d = S_ARM;
          ovr_clr = 1'b1;
        end
      end
      S_ARM: begin
        timer_d = '0;
        acc_l_d = '0;
        acc_r_d = '0;
        state_d = enable ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (!enable) begin
          state_d = S_IDLE;
          timer_d = '0;
          acc_l_d = '0;
          acc_r_d = '0;
        end else if (timer_q == LAST_TICK) begin
          snap_fire = 1'b1;
          speed_l_d = new_l;
          speed_r_d = new_r;
          timer_d   = '0;
          acc_l_d   = '0;
          acc_r_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
          acc_l_d = new_l;
          acc_r_d = new_r;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A snapshot landing together with rd_ack counts as consumed-then-refilled.
    if (snap_fire) begin
      snap_d = 1'b1;
      if (snap_q && !rd_ack) ovr_d = 1'b1;
    end else if (rd_ack && snap_q) begin
      snap_d = 1'b0;
    end
    if (ovr_clr) ovr_d = 1'b0;

    busy_d = (state_d == S_RUN);
  end

  assign speed_left  = speed_l_q;
  assign speed_right = speed_r_q;
  assign snap_valid  = snap_q;
  assign overrun     = ovr_q;
  assign err_count   = err_q;
  assign busy        = busy_q;

endmodule
